// File: rtl/spi_sck_gen_if.sv
// Bus between the SPI_APB register block (master) and the SCK/frame
// generator (slave): frame request and configuration in, SPI pins and
// strobes out.
interface spi_sck_gen_if #(
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 5,
    parameter int NUM_SS = 4,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic              transfer_start;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  baud_rate;
    logic [LEN_W-1:0]  data_len;
    logic [SS_W-1:0]   ss_sel;
    logic              sck;
    logic [NUM_SS-1:0] ss_n;
    logic              shift_en;
    logic              sample_en;
    logic              busy;
    logic [LEN_W:0]    bit_cnt;
    logic              transfer_complete;

    modport master (
        output transfer_start, cpol, cpha, baud_rate, data_len, ss_sel,
        input  sck, ss_n, shift_en, sample_en, busy, bit_cnt, transfer_complete
    );

    modport slave (
        input  transfer_start, cpol, cpha, baud_rate, data_len, ss_sel,
        output sck, ss_n, shift_en, sample_en, busy, bit_cnt, transfer_complete
    );
endinterface

// File: rtl/spi_sck_gen.sv
// SPI master clock / frame generator. One pclk domain, all outputs
// registered. A frame is IDLE -> SETUP (H cycles) -> XFER (2N sck toggles,
// one every H cycles) -> HOLD (H cycles) -> IDLE, with H = baud_rate+1 and
// N = data_len+1.
// Optional macro SPI_CONT_XFER_EN: a request present at the edge ending HOLD
// chains straight into a new frame without releasing slave select.
module spi_sck_gen #(
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 5,
    parameter int NUM_SS = 4,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic         pclk,
    input  logic         preset,
    spi_sck_gen_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] lat_baud;
    logic [LEN_W-1:0] lat_len;
    logic             lat_cpha;
    // number of sck toggles already issued in this frame (0..2N)
    logic [LEN_W+1:0] tog;

    logic [LEN_W+1:0]  tog_nxt;
    logic [LEN_W+1:0]  tog_last;
    logic              period_end;
    logic              leading;
    logic              last_tog;
    logic [NUM_SS-1:0] ss_dec;

    // Toggle bookkeeping: toggle numbers are 1-based, odd ones are leading.
    // The sck register itself carries the latched idle level through the
    // frame, since an even toggle count always brings it back to cpol.
    always_comb begin
        tog_nxt    = tog + 1'b1;
        tog_last   = {1'b0, lat_len, 1'b1} + 1'b1;
        period_end = (div == lat_baud);
        leading    = tog_nxt[0];
        last_tog   = (tog_nxt == tog_last);
    end

    // Active-low one-hot select; an out-of-range index selects nobody.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (bus.ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
    end

    // Frame sequencer, divider and registered outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state                 <= IDLE;
            div                   <= '0;
            lat_baud              <= '0;
            lat_len               <= '0;
            lat_cpha              <= 1'b0;
            tog                   <= '0;
            bus.sck               <= 1'b0;
            bus.ss_n              <= '1;
            bus.shift_en          <= 1'b0;
            bus.sample_en         <= 1'b0;
            bus.busy              <= 1'b0;
            bus.bit_cnt           <= '0;
            bus.transfer_complete <= 1'b0;
        end else begin
            bus.shift_en          <= 1'b0;
            bus.sample_en         <= 1'b0;
            bus.transfer_complete <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sck <= bus.cpol;
                    if (bus.transfer_start) begin
                        lat_baud    <= bus.baud_rate;
                        lat_len     <= bus.data_len;
                        lat_cpha    <= bus.cpha;
                        bus.ss_n    <= ss_dec;
                        bus.busy    <= 1'b1;
                        bus.bit_cnt <= '0;
                        div         <= '0;
                        tog         <= '0;
                        state       <= SETUP;
                    end
                end
                SETUP, XFER: begin
                    if (period_end) begin
                        div     <= '0;
                        bus.sck <= ~bus.sck;
                        tog     <= tog_nxt;
                        // cpha=0 samples on leading edges, cpha=1 on trailing
                        if (leading ^ lat_cpha) begin
                            bus.sample_en <= 1'b1;
                            bus.bit_cnt   <= bus.bit_cnt + 1'b1;
                        end
                        // cpha=0 never shifts after the final sample: bit 0
                        // was preloaded when ss went low
                        bus.shift_en <= lat_cpha ? leading : (!leading && !last_tog);
                        state        <= last_tog ? HOLD : XFER;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                HOLD: begin
                    if (period_end) begin
                        div                   <= '0;
                        bus.transfer_complete <= 1'b1;
`ifdef SPI_CONT_XFER_EN
                        if (bus.transfer_start) begin
                            // chained frame keeps the current slave selected
                            lat_baud    <= bus.baud_rate;
                            lat_len     <= bus.data_len;
                            lat_cpha    <= bus.cpha;
                            bus.sck     <= bus.cpol;
                            bus.bit_cnt <= '0;
                            tog         <= '0;
                            state       <= SETUP;
                        end else begin
                            bus.ss_n <= '1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
`else
                        bus.ss_n <= '1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
`endif
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sck_gen.sv
// Self-checking bench for spi_sck_gen. Expected pin values for every cycle
// of a frame are computed from the frame timing rules (toggle j of 2N lands
// H*j cycles after the accepted request) rather than from a state machine.
module tb_spi_sck_gen;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 5;
    localparam int NUM_SS = 5;
    localparam int SS_W   = 3;

    logic pclk = 1'b0;
    logic preset;
    int   checks = 0;
    int   failures = 0;
    int   cur_d = 0;

    int f_cpol, f_cpha, f_h, f_n, f_sel;
    int in_cpol;

    always #5 pclk = ~pclk;

    spi_sck_gen_if #(.DIV_W(DIV_W), .LEN_W(LEN_W), .NUM_SS(NUM_SS), .SS_W(SS_W)) bus ();

    spi_sck_gen #(.DIV_W(DIV_W), .LEN_W(LEN_W), .NUM_SS(NUM_SS), .SS_W(SS_W)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s d=%0d got=%0h expected=%0h", tag, cur_d, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input int st, input int cp, input int ph, input int br,
                         input int dl, input int sl);
        bus.transfer_start = st[0];
        bus.cpol           = cp[0];
        bus.cpha           = ph[0];
        bus.baud_rate      = DIV_W'(br);
        bus.data_len       = LEN_W'(dl);
        bus.ss_sel         = SS_W'(sl);
        in_cpol            = cp;
    endtask

    function automatic logic [31:0] ss_exp(input int sel);
        logic [31:0] v;
        v = (32'd1 << NUM_SS) - 1;
        if (sel < NUM_SS) v[sel] = 1'b0;
        return v;
    endfunction

    // Expected outputs d cycles after the edge that accepted the request.
    task automatic check_at(input int d);
        int T, cnt, j, e_sck, e_sh, e_sa, e_bc, e_busy, e_cmp;
        logic [31:0] e_ss;
        cur_d = d;
        T = (2 * f_n + 1) * f_h;
        e_sh = 0; e_sa = 0; e_cmp = 0;
        if (d < T) begin
            cnt    = d / f_h;
            e_sck  = f_cpol ^ (cnt % 2);
            j      = (d > 0 && d % f_h == 0) ? d / f_h : 0;
            if (j > 0) begin
                e_sa = f_cpha ? (j % 2 == 0) : (j % 2 == 1);
                e_sh = f_cpha ? (j % 2 == 1) : (j % 2 == 0 && j != 2 * f_n);
            end
            e_bc   = f_cpha ? cnt / 2 : (cnt + 1) / 2;
            e_busy = 1;
            e_ss   = ss_exp(f_sel);
        end else begin
            e_sck  = (d == T) ? f_cpol : in_cpol;
            e_cmp  = (d == T);
            e_bc   = f_n;
            e_busy = 0;
            e_ss   = ss_exp(NUM_SS);
        end
        chk("sck", bus.sck, e_sck);
        chk("ss_n", bus.ss_n, e_ss);
        chk("shift_en", bus.shift_en, e_sh);
        chk("sample_en", bus.sample_en, e_sa);
        chk("busy", bus.busy, e_busy);
        chk("bit_cnt", bus.bit_cnt, e_bc);
        chk("transfer_complete", bus.transfer_complete, e_cmp);
    endtask

    // One frame; noise scrambles every input (including re-requests) while
    // busy, stopping before the HOLD-ending edge. gap = idle cycles after.
    task automatic run_frame(input int cp, input int ph, input int br, input int dl,
                             input int sl, input bit noise, input int gap);
        int T;
        f_cpol = cp; f_cpha = ph; f_h = br + 1; f_n = dl + 1; f_sel = sl;
        T = (2 * f_n + 1) * f_h;
        drive(1, cp, ph, br, dl, sl);
        tick();
        for (int d = 0; d <= T + gap; d++) begin
            check_at(d);
            if (noise && d + 1 < T)
                drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 7));
            else
                drive(0, cp, ph, br, dl, sl);
            if (d < T + gap) tick();
        end
    endtask

    task automatic reset_test();
        f_cpol = 0; f_cpha = 0; f_h = 2; f_n = 8; f_sel = 1;
        drive(1, 0, 0, 1, 7, 1);
        tick();
        for (int d = 0; d < 10; d++) begin
            check_at(d);
            drive(0, 1, 0, 1, 7, 1);
            tick();
        end
        cur_d = 10;
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("rst_sck", bus.sck, 0);
        chk("rst_ss_n", bus.ss_n, ss_exp(NUM_SS));
        chk("rst_busy", bus.busy, 0);
        chk("rst_bit_cnt", bus.bit_cnt, 0);
        chk("rst_complete", bus.transfer_complete, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            cur_d = 11 + i;
            chk("post_rst_sck", bus.sck, in_cpol);
            chk("post_rst_busy", bus.busy, 0);
            chk("post_rst_complete", bus.transfer_complete, 0);
        end
    endtask

`ifdef SPI_CONT_XFER_EN
    task automatic cont_test();
        drive(1, 0, 0, 1, 3, 2);
        tick();
        for (int d = 0; d <= 37; d++) begin
            cur_d = d;
            chk("cont_complete", bus.transfer_complete, (d == 18 || d == 36));
            chk("cont_busy", bus.busy, d < 36);
            chk("cont_ss_n", bus.ss_n, (d < 36) ? ss_exp(2) : ss_exp(NUM_SS));
            if (d == 34) drive(0, 0, 0, 1, 3, 2);
            tick();
        end
    endtask
`endif

    initial begin
        preset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        cur_d = 0;
        chk("reset_sck", bus.sck, 0);
        chk("reset_ss_n", bus.ss_n, ss_exp(NUM_SS));
        chk("reset_busy", bus.busy, 0);
        chk("reset_strobes", {bus.shift_en, bus.sample_en, bus.transfer_complete}, 0);
        chk("reset_bit_cnt", bus.bit_cnt, 0);
        preset = 1'b0;
        tick();

        run_frame(0, 0, 1, 7, 2, 0, 1);     // mode 0, 8 bits
        run_frame(1, 1, 0, 0, 0, 0, 1);     // mode 3, single bit, H=1
        run_frame(0, 1, 3, 31, 3, 0, 0);    // mode 1, 32 bits, back-to-back
        run_frame(1, 0, 3, 31, 4, 0, 2);    // mode 2, 32 bits
        run_frame(0, 0, 2, 9, 1, 1, 1);     // mid-frame noise ignored
        run_frame(1, 1, 255, 1, 6, 0, 1);   // max divider, no slave selected
        reset_test();
        run_frame(0, 0, 1, 7, 2, 0, 1);     // normal frame after abort

        for (int i = 0; i < 30; i++) begin
            int br;
            br = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 3);
            run_frame($urandom_range(0, 1), $urandom_range(0, 1), br,
                      (br == 255) ? $urandom_range(0, 1) : $urandom_range(0, 31),
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2));
        end

`ifdef SPI_CONT_XFER_EN
        cont_test();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_sck_gen.md
Name: spi_sck_gen

Overview:
- Parametrised SPI master clock/frame generator for the SPI_APB peripheral.
- Runs from a single bus clock and supports all four CPOL/CPHA modes.
- Has a programmable baud divider, variable frame length and multiple decoded slave selects.
- Emits single-cycle shift/sample strobes to the shift register and a transfer_complete pulse to the APB register block.

Parameters:
- DIV_W, 8, width of the baud_rate divider field
- LEN_W, 5, width of data_len; frame length N = data_len+1 bits (1..2^LEN_W)
- NUM_SS, 4, number of slave-select outputs
- SS_W, $clog2(NUM_SS) (min 1), width of ss_sel

Ports:
- pclk  in  1  sole clock
- preset  in  1  reset
- transfer_start  in  1  frame request; sampled only in IDLE
- cpol  in  1  clock idle level
- cpha  in  1  0: sample on leading edge; 1: shift on leading edge
- baud_rate  in  DIV_W  half period H = baud_rate+1 pclk cycles
- data_len  in  LEN_W  bits per frame minus one
- ss_sel  in  SS_W  slave index
- sck  out  1  serial clock
- ss_n  out  NUM_SS  active-low slave selects
- shift_en  out  1  one-cycle strobe: drive next bit
- sample_en  out  1  one-cycle strobe: capture MISO
- busy  out  1  frame in progress
- bit_cnt  out  LEN_W+1  sample_en pulses issued in the current frame
- transfer_complete  out  1  one-cycle end-of-frame pulse

Behaviour:
- Interface (already decided): one clock, pclk. Reset preset is synchronous and active-high. All outputs are registered.
- Reset values:
  - sck=0, ss_n=all ones.
  - shift_en, sample_en, busy, transfer_complete = 0; bit_cnt = 0.
  - FSM=IDLE, divider=0.
- IDLE:
  - sck <= cpol every cycle.
  - transfer_start=1 at edge k latches cpol, cpha, baud_rate, data_len and ss_sel.
  - At the same edge k: busy<=1, ss_n[ss_sel]<=0, bit_cnt<=0, FSM->SETUP.
  - Inputs changing mid-frame have no effect.
- SETUP: hold for H cycles, then FSM->XFER with the first sck toggle at edge k+H.
- XFER:
  - sck toggles every H cycles, 2N toggles in total, at k+H ... k+2N·H.
  - Odd-numbered toggles are leading edges; even-numbered toggles are trailing edges.
  - After the 2N-th toggle, FSM->HOLD.
- Strobe placement (strobes register high at the same edge sck toggles):
  - cpha=0: sample_en on every leading edge; shift_en on every trailing edge except the last. N sample_en, N-1 shift_en (bit 0 is preloaded on ss assertion).
  - cpha=1: shift_en on every leading edge; sample_en on every trailing edge. N of each.
  - bit_cnt increments with each sample_en and reaches N.
- HOLD:
  - Lasts H cycles with sck at cpol and ss still low.
  - At edge k+(2N+1)H: ss_n<=all ones, busy<=0, transfer_complete<=1 for one cycle, FSM->IDLE.
- Timing: frame length from request to release is (2N+1)·H cycles. A new request is accepted no earlier than the cycle after transfer_complete.
- Boundary conditions:
  - baud_rate=0: H=1, sck toggles every cycle.
  - Maximum baud_rate: divider must not overflow (counter DIV_W bits, compared to latched value).
  - data_len=0: single-bit frame, 2 sck toggles.
  - ss_sel>=NUM_SS: frame runs normally, no ss_n line asserted.
  - transfer_start while busy: ignored, not queued.
  - preset mid-frame: reset values at the next edge, frame aborted, no transfer_complete.

Optional Feature:
- Macro: SPI_CONT_XFER_EN (continuous frames).
- Defined: if transfer_start=1 at the edge ending HOLD, then:
  - ss_n stays asserted and busy stays 1.
  - transfer_complete still pulses; bit_cnt<=0.
  - Config is re-latched except ss_sel, which is retained.
  - FSM->SETUP directly, giving back-to-back frames with a gap of H+H cycles between the last and first sck edges.
- Undefined: ss_n always releases between frames as described above.

Test Plan:
- Mode 0, baud_rate=1, data_len=7, ss_sel=2, start at edge 0 -> ss_n=4'b1011 from edge 0; sck rises at 2, last fall at 32; 8 sample_en, 7 shift_en; transfer_complete at 34; bit_cnt=8.
- Mode 3 (cpol=1, cpha=1), baud_rate=0, data_len=0 -> sck idles 1; falls at 1, rises at 2; shift_en at 1, sample_en at 2; complete at 3.
- Modes 1 and 2 with data_len=31, baud_rate=3 -> 64 toggles at 4-cycle spacing; strobe edges per cpha; frame of 260 cycles.
- transfer_start re-pulsed mid-frame and baud_rate changed mid-frame -> no effect on timing; a second request after complete starts a new frame.
- preset asserted at cycle 10 of a frame -> next edge: ss_n all ones, sck=0, busy=0, no transfer_complete; a new frame then runs normally.
- SPI_CONT_XFER_EN defined, transfer_start held high, baud_rate=1, data_len=3 -> ss_n stays low across two frames; transfer_complete at 18 and 36.
